hwpe_ctrl_regfile_ctx: RTL and testbench

- Multi-context job register file for HWPE control slaves; successor of the single-context flop register file.
- Producer side programs a "pending" context via one byte-enabled write port, then commits it; consumer side reads the oldest committed ("running") context via NumRdPorts registered read ports, then releases it with done_i.
- Contexts are managed as a circular queue, so software can program job N+1 while the datapath executes job N.

---
 rtl/hwpe_ctrl_regfile_ctx.sv | 177 +++++++++++++++++
 tb/tb_hwpe_ctrl_regfile_ctx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_regfile_ctx.sv
// hwpe_ctrl_regfile_ctx
// Multi-context job register file for HWPE control slaves. Contexts form a
// circular queue: the producer programs the pending context (wr_ptr) through
// one byte-enabled write port and commits it; the consumer reads the oldest
// committed context (rd_ptr) through NumRdPorts registered read ports and
// releases it with done_i.
//
// Ports:
//   clk_int, rst_ni (async, active-low), clear_i (sync clear, top priority)
//   wr_en_i/wr_addr_i/wr_data_i/wr_be_i : write into the pending context
//   commit_i                            : enqueue the pending context
//   done_i                              : release the running context
//   rd_en_i/rd_addr_i -> rd_data_o/rd_valid_o : per-port reads, latency 1
//   wr_ctx_o/rd_ctx_o                   : pending / running context index
//   count_o/full_o/empty_o              : committed-context occupancy
//   err_o                               : one-cycle pulse on a dropped request
//   mem_content_o                       : running context contents (false path)
module hwpe_ctrl_regfile_ctx #(
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumRegs     = 24,
  parameter int unsigned NumContexts = 2,
  parameter int unsigned NumRdPorts  = 2,
  localparam int unsigned CtxW       = (NumContexts > 2) ? $clog2(NumContexts) : 1,
  localparam int unsigned CntW       = $clog2(NumContexts + 1),
  localparam int unsigned NumByte    = DataWidth / 8
) (
  input  logic                            clk_int,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            wr_en_i,
  input  logic [AddrWidth-1:0]            wr_addr_i,
  input  logic [DataWidth-1:0]            wr_data_i,
  input  logic [NumByte-1:0]              wr_be_i,
  input  logic                            commit_i,
  input  logic                            done_i,
  input  logic [NumRdPorts-1:0]           rd_en_i,
  input  logic [NumRdPorts*AddrWidth-1:0] rd_addr_i,
  output logic [NumRdPorts*DataWidth-1:0] rd_data_o,
  output logic [NumRdPorts-1:0]           rd_valid_o,
  output logic [CtxW-1:0]                 wr_ctx_o,
  output logic [CtxW-1:0]                 rd_ctx_o,
  output logic [CntW-1:0]                 count_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            err_o,
  output logic [NumRegs*DataWidth-1:0]    mem_content_o
);

  // One extra bit so NumRegs == 2**AddrWidth is still representable.
  localparam logic [AddrWidth:0] RegLimit = NumRegs[AddrWidth:0];
  localparam logic [CtxW-1:0]    LastCtx  = CtxW'(NumContexts - 1);
  localparam logic [CntW-1:0]    FullCnt  = CntW'(NumContexts);

  logic [DataWidth-1:0]            mem [NumContexts][NumRegs];
  logic [CtxW-1:0]                 wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CntW-1:0]                 count, count_d;
  logic                            full, empty;
  logic                            wr_addr_ok, wr_ok, commit_ok, done_ok, err_d;
  logic [NumRdPorts*DataWidth-1:0] rd_data, rd_data_d;
  logic [NumRdPorts-1:0]           rd_valid;
  logic                            err;

  assign full  = (count == FullCnt);
  assign empty = (count == {CntW{1'b0}});

  // Request qualification and pointer/count next state, all on pre-edge full/empty.
  always_comb begin
    wr_addr_ok = ({1'b0, wr_addr_i} < RegLimit);
    wr_ok      = wr_en_i & ~full & wr_addr_ok;
    commit_ok  = commit_i & ~full;
    done_ok    = done_i & ~empty;
    err_d      = (wr_en_i & (full | ~wr_addr_ok)) | (commit_i & full) | (done_i & empty);

    if (commit_ok) begin
      wr_ptr_d = (wr_ptr == LastCtx) ? {CtxW{1'b0}} : wr_ptr + {{(CtxW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr;
    end

    if (done_ok) begin
      rd_ptr_d = (rd_ptr == LastCtx) ? {CtxW{1'b0}} : rd_ptr + {{(CtxW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr;
    end

    case ({commit_ok, done_ok})
      2'b10:   count_d = count + {{(CntW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count - {{(CntW-1){1'b0}}, 1'b1};
      default: count_d = count;
    endcase
  end

  // Read mux: empty queue or out-of-range index returns zero.
  always_comb begin
    rd_data_d = '0;
    for (int p = 0; p < NumRdPorts; p++) begin
      if (!empty && ({1'b0, rd_addr_i[p*AddrWidth +: AddrWidth]} < RegLimit)) begin
        rd_data_d[p*DataWidth +: DataWidth] = mem[rd_ptr][rd_addr_i[p*AddrWidth +: AddrWidth]];
      end else begin
        rd_data_d[p*DataWidth +: DataWidth] = '0;
      end
    end
  end

  // Flatten the running context for the false-path debug output.
  always_comb begin
    mem_content_o = '0;
    for (int r = 0; r < NumRegs; r++) begin
      mem_content_o[r*DataWidth +: DataWidth] = mem[rd_ptr][r];
    end
  end

  // Register storage with byte-enabled writes into the pending context.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumContexts; c++) begin
        for (int r = 0; r < NumRegs; r++) begin
          mem[c][r] <= '0;
        end
      end
    end else if (clear_i) begin
      for (int c = 0; c < NumContexts; c++) begin
        for (int r = 0; r < NumRegs; r++) begin
          mem[c][r] <= '0;
        end
      end
    end else if (wr_ok) begin
      for (int b = 0; b < NumByte; b++) begin
        if (wr_be_i[b]) begin
          mem[wr_ptr][wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Queue pointers, occupancy, error pulse and registered read ports.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      count    <= count_d;
      err      <= err_d;
      rd_valid <= rd_en_i;
      for (int p = 0; p < NumRdPorts; p++) begin
        // Data holds its last value while the port is idle.
        if (rd_en_i[p]) begin
          rd_data[p*DataWidth +: DataWidth] <= rd_data_d[p*DataWidth +: DataWidth];
        end
      end
    end
  end

  assign rd_data_o  = rd_data;
  assign rd_valid_o = rd_valid;
  assign wr_ctx_o   = wr_ptr;
  assign rd_ctx_o   = rd_ptr;
  assign count_o    = count;
  assign full_o     = full;
  assign empty_o    = empty;
  assign err_o      = err;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_ctx.sv
// Self-checking bench for hwpe_ctrl_regfile_ctx (default parameters).
// Reads push their expected data onto a per-port scoreboard queue when issued;
// the data is popped and compared when rd_valid_o comes back one cycle later.
module tb_hwpe_ctrl_regfile_ctx;
  localparam int NR = 24;
  localparam int DW = 32;

  logic             clk_int = 1'b0;
  logic             rst_ni, clear_i, wr_en_i, commit_i, done_i;
  logic [4:0]       wr_addr_i;
  logic [31:0]      wr_data_i;
  logic [3:0]       wr_be_i;
  logic [1:0]       rd_en_i;
  logic [9:0]       rd_addr_i;
  logic [63:0]      rd_data_o;
  logic [1:0]       rd_valid_o;
  logic [0:0]       wr_ctx_o, rd_ctx_o;
  logic [1:0]       count_o;
  logic             full_o, empty_o, err_o;
  logic [NR*DW-1:0] mem_content_o;

  logic [31:0] sb0[$];
  logic [31:0] sb1[$];
  logic [31:0] exp;
  int n_cmp = 0;
  int n_err = 0;

  hwpe_ctrl_regfile_ctx dut (
    .clk_int(clk_int), .rst_ni(rst_ni), .clear_i(clear_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
    .commit_i(commit_i), .done_i(done_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .wr_ctx_o(wr_ctx_o), .rd_ctx_o(rd_ctx_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o),
    .mem_content_o(mem_content_o)
  );

  always #5 clk_int = ~clk_int;

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic idle();
    clear_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = 5'd0; wr_data_i = 32'd0; wr_be_i = 4'd0;
    commit_i = 1'b0; done_i = 1'b0; rd_en_i = 2'b00; rd_addr_i = 10'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_be_i = be;
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [31:0] e);
    rd_en_i[p] = 1'b1;
    rd_addr_i[p*5 +: 5] = a;
    if (p == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; idle();
    repeat (2) tick();
    n_cmp++; if (count_o !== 2'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count_o); end
    n_cmp++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin n_err++; $display("FAIL rst_flags: empty=%b full=%b want 1/0", empty_o, full_o); end
    n_cmp++; if (wr_ctx_o !== 1'b0 || rd_ctx_o !== 1'b0) begin n_err++; $display("FAIL rst_ptrs: wr=%0d rd=%0d want 0/0", wr_ctx_o, rd_ctx_o); end
    n_cmp++; if (err_o !== 1'b0 || rd_valid_o !== 2'b00 || rd_data_o !== 64'd0) begin n_err++; $display("FAIL rst_outs: err=%b valid=%b data=%h want 0", err_o, rd_valid_o, rd_data_o); end
    rst_ni = 1'b1;
    tick();
    rd(0, 5'd0, 32'd0);
    tick(); idle();
    exp = sb0.pop_front();
    n_cmp++; if (rd_valid_o[0] !== 1'b1 || rd_data_o[31:0] !== exp) begin n_err++; $display("FAIL rst_read: valid=%b data=%h want 1/%h", rd_valid_o[0], rd_data_o[31:0], exp); end
    n_cmp++; if (rd_valid_o[1] !== 1'b0 || empty_o !== 1'b1 || count_o !== 2'd0) begin n_err++; $display("FAIL rst_read_state: v1=%b empty=%b count=%0d want 0/1/0", rd_valid_o[1], empty_o, count_o); end
  endtask

  task automatic test_byte_write();
    wr(5'd3, 32'hAABBCCDD, 4'b1111); tick();
    wr(5'd3, 32'h11223344, 4'b0101); tick(); idle();
    commit_i = 1'b1; tick(); idle();
    n_cmp++; if (count_o !== 2'd1 || wr_ctx_o !== 1'b1 || rd_ctx_o !== 1'b0) begin n_err++; $display("FAIL bw_commit: count=%0d wr=%0d rd=%0d want 1/1/0", count_o, wr_ctx_o, rd_ctx_o); end
    n_cmp++; if (empty_o !== 1'b0 || full_o !== 1'b0 || err_o !== 1'b0) begin n_err++; $display("FAIL bw_flags: empty=%b full=%b err=%b want 0/0/0", empty_o, full_o, err_o); end
    n_cmp++; if (mem_content_o[3*DW +: DW] !== 32'hAA22CC44) begin n_err++; $display("FAIL bw_content: got %h want aa22cc44", mem_content_o[3*DW +: DW]); end
    rd(0, 5'd3, 32'hAA22CC44); rd(1, 5'd3, 32'hAA22CC44);
    tick(); idle();
    exp = sb0.pop_front();
    n_cmp++; if (rd_valid_o[0] !== 1'b1 || rd_data_o[31:0] !== exp) begin n_err++; $display("FAIL bw_rd0: valid=%b data=%h want 1/%h", rd_valid_o[0], rd_data_o[31:0], exp); end
    exp = sb1.pop_front();
    n_cmp++; if (rd_valid_o[1] !== 1'b1 || rd_data_o[63:32] !== exp) begin n_err++; $display("FAIL bw_rd1: valid=%b data=%h want 1/%h", rd_valid_o[1], rd_data_o[63:32], exp); end
    tick();
    n_cmp++; if (rd_valid_o !== 2'b00 || rd_data_o[31:0] !== 32'hAA22CC44) begin n_err++; $display("FAIL bw_hold: valid=%b data=%h want 00/aa22cc44", rd_valid_o, rd_data_o[31:0]); end
  endtask

  task automatic test_full();
    wr(5'd5, 32'h55550001, 4'b1111); commit_i = 1'b1; tick(); idle();
    n_cmp++; if (count_o !== 2'd2 || full_o !== 1'b1 || wr_ctx_o !== 1'b0 || err_o !== 1'b0) begin n_err++; $display("FAIL full_reach: count=%0d full=%b wr=%0d err=%b want 2/1/0/0", count_o, full_o, wr_ctx_o, err_o); end
    commit_i = 1'b1; tick(); idle();
    n_cmp++; if (err_o !== 1'b1 || count_o !== 2'd2 || wr_ctx_o !== 1'b0) begin n_err++; $display("FAIL full_commit: err=%b count=%0d wr=%0d want 1/2/0", err_o, count_o, wr_ctx_o); end
    tick();
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL full_err_pulse: got %b want 0", err_o); end
    wr(5'd0, 32'hFFFFFFFF, 4'b1111); tick(); idle();
    n_cmp++; if (err_o !== 1'b1 || count_o !== 2'd2) begin n_err++; $display("FAIL full_write: err=%b count=%0d want 1/2", err_o, count_o); end
    n_cmp++; if (mem_content_o[0 +: DW] !== 32'd0 || mem_content_o[3*DW +: DW] !== 32'hAA22CC44) begin n_err++; $display("FAIL full_content: r0=%h r3=%h want 0/aa22cc44", mem_content_o[0 +: DW], mem_content_o[3*DW +: DW]); end
    commit_i = 1'b1; done_i = 1'b1; rd(0, 5'd3, 32'hAA22CC44);
    tick(); idle();
    n_cmp++; if (err_o !== 1'b1 || count_o !== 2'd1 || wr_ctx_o !== 1'b0 || rd_ctx_o !== 1'b1) begin n_err++; $display("FAIL full_cd: err=%b count=%0d wr=%0d rd=%0d want 1/1/0/1", err_o, count_o, wr_ctx_o, rd_ctx_o); end
    exp = sb0.pop_front();
    n_cmp++; if (rd_valid_o[0] !== 1'b1 || rd_data_o[31:0] !== exp) begin n_err++; $display("FAIL full_rd_released: valid=%b data=%h want 1/%h", rd_valid_o[0], rd_data_o[31:0], exp); end
  endtask

  task automatic test_commit_done();
    commit_i = 1'b1; done_i = 1'b1; rd(0, 5'd5, 32'h55550001);
    tick(); idle();
    n_cmp++; if (count_o !== 2'd1 || wr_ctx_o !== 1'b1 || rd_ctx_o !== 1'b0 || err_o !== 1'b0) begin n_err++; $display("FAIL cd_first: count=%0d wr=%0d rd=%0d err=%b want 1/1/0/0", count_o, wr_ctx_o, rd_ctx_o, err_o); end
    exp = sb0.pop_front();
    n_cmp++; if (rd_valid_o[0] !== 1'b1 || rd_data_o[31:0] !== exp) begin n_err++; $display("FAIL cd_rd: valid=%b data=%h want 1/%h", rd_valid_o[0], rd_data_o[31:0], exp); end
    commit_i = 1'b1; done_i = 1'b1; tick(); idle();
    n_cmp++; if (count_o !== 2'd1 || wr_ctx_o !== 1'b0 || rd_ctx_o !== 1'b1) begin n_err++; $display("FAIL cd_wrap: count=%0d wr=%0d rd=%0d want 1/0/1", count_o, wr_ctx_o, rd_ctx_o); end
    n_cmp++; if (mem_content_o[5*DW +: DW] !== 32'h55550001) begin n_err++; $display("FAIL cd_stale: got %h want 55550001", mem_content_o[5*DW +: DW]); end
  endtask

  task automatic test_illegal();
    wr(5'd30, 32'h12345678, 4'b1111); tick(); idle();
    n_cmp++; if (err_o !== 1'b1 || count_o !== 2'd1) begin n_err++; $display("FAIL ill_wr_addr: err=%b count=%0d want 1/1", err_o, count_o); end
    rd(1, 5'd30, 32'd0); tick(); idle();
    exp = sb1.pop_front();
    n_cmp++; if (rd_valid_o[1] !== 1'b1 || rd_data_o[63:32] !== exp || err_o !== 1'b0) begin n_err++; $display("FAIL ill_rd_addr: valid=%b data=%h err=%b want 1/%h/0", rd_valid_o[1], rd_data_o[63:32], err_o, exp); end
    done_i = 1'b1; tick(); idle();
    n_cmp++; if (count_o !== 2'd0 || empty_o !== 1'b1 || rd_ctx_o !== 1'b0 || err_o !== 1'b0) begin n_err++; $display("FAIL ill_drain: count=%0d empty=%b rd=%0d err=%b want 0/1/0/0", count_o, empty_o, rd_ctx_o, err_o); end
    done_i = 1'b1; tick(); idle();
    n_cmp++; if (err_o !== 1'b1 || count_o !== 2'd0 || rd_ctx_o !== 1'b0) begin n_err++; $display("FAIL ill_done_empty: err=%b count=%0d rd=%0d want 1/0/0", err_o, count_o, rd_ctx_o); end
    rd(0, 5'd3, 32'd0); tick(); idle();
    exp = sb0.pop_front();
    n_cmp++; if (rd_valid_o[0] !== 1'b1 || rd_data_o[31:0] !== exp) begin n_err++; $display("FAIL ill_rd_empty: valid=%b data=%h want 1/%h", rd_valid_o[0], rd_data_o[31:0], exp); end
    commit_i = 1'b1; done_i = 1'b1; tick(); idle();
    n_cmp++; if (err_o !== 1'b1 || count_o !== 2'd1 || wr_ctx_o !== 1'b1 || rd_ctx_o !== 1'b0) begin n_err++; $display("FAIL ill_cd_empty: err=%b count=%0d wr=%0d rd=%0d want 1/1/1/0", err_o, count_o, wr_ctx_o, rd_ctx_o); end
  endtask

  task automatic test_clear();
    rd(1, 5'd3, 32'hAA22CC44); tick(); idle();
    exp = sb1.pop_front();
    n_cmp++; if (rd_valid_o[1] !== 1'b1 || rd_data_o[63:32] !== exp) begin n_err++; $display("FAIL clr_pre_rd: valid=%b data=%h want 1/%h", rd_valid_o[1], rd_data_o[63:32], exp); end
    clear_i = 1'b1; wr(5'd7, 32'hCAFEF00D, 4'b1111); commit_i = 1'b1; done_i = 1'b1;
    rd_en_i = 2'b11; rd_addr_i = {5'd3, 5'd3};
    tick(); idle();
    n_cmp++; if (count_o !== 2'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin n_err++; $display("FAIL clr_count: count=%0d empty=%b full=%b want 0/1/0", count_o, empty_o, full_o); end
    n_cmp++; if (wr_ctx_o !== 1'b0 || rd_ctx_o !== 1'b0 || err_o !== 1'b0) begin n_err++; $display("FAIL clr_ptrs: wr=%0d rd=%0d err=%b want 0/0/0", wr_ctx_o, rd_ctx_o, err_o); end
    n_cmp++; if (rd_valid_o !== 2'b00 || rd_data_o !== 64'd0) begin n_err++; $display("FAIL clr_rd: valid=%b data=%h want 0/0", rd_valid_o, rd_data_o); end
    commit_i = 1'b1; tick(); idle();
    n_cmp++; if (wr_ctx_o !== 1'b1 || count_o !== 2'd1 || mem_content_o !== '0) begin n_err++; $display("FAIL clr_after: wr=%0d count=%0d content_nonzero=%b want 1/1/0", wr_ctx_o, count_o, |mem_content_o); end
  endtask

  task automatic test_async_reset();
    wr(5'd5, 32'hDEADBEEF, 4'b1111); commit_i = 1'b1; rd_en_i = 2'b01; rd_addr_i = 10'd3;
    #2; rst_ni = 1'b0; #1;
    n_cmp++; if (count_o !== 2'd0 || empty_o !== 1'b1 || wr_ctx_o !== 1'b0 || rd_ctx_o !== 1'b0) begin n_err++; $display("FAIL arst_state: count=%0d empty=%b wr=%0d rd=%0d want 0/1/0/0", count_o, empty_o, wr_ctx_o, rd_ctx_o); end
    n_cmp++; if (rd_valid_o !== 2'b00 || rd_data_o !== 64'd0 || err_o !== 1'b0) begin n_err++; $display("FAIL arst_outs: valid=%b data=%h err=%b want 0", rd_valid_o, rd_data_o, err_o); end
    tick(); idle(); rst_ni = 1'b1;
    commit_i = 1'b1; tick(); idle();
    n_cmp++; if (wr_ctx_o !== 1'b1 || count_o !== 2'd1 || mem_content_o !== '0) begin n_err++; $display("FAIL arst_after: wr=%0d count=%0d content_nonzero=%b want 1/1/0", wr_ctx_o, count_o, |mem_content_o); end
    rd(0, 5'd5, 32'd0); tick(); idle();
    exp = sb0.pop_front();
    n_cmp++; if (rd_valid_o[0] !== 1'b1 || rd_data_o[31:0] !== exp) begin n_err++; $display("FAIL arst_rd: valid=%b data=%h want 1/%h", rd_valid_o[0], rd_data_o[31:0], exp); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_byte_write();
    test_full();
    test_commit_done();
    test_illegal();
    test_clear();
    test_async_reset();
    n_cmp++; if (sb0.size() != 0 || sb1.size() != 0) begin n_err++; $display("FAIL sb_drain: left %0d/%0d want 0/0", sb0.size(), sb1.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
